// File: rtl/edge_to_level_gen.sv
// edge_to_level_gen: rebuilds a level waveform from one-cycle toggle strobes.
// Every toggle is followed by a minimum hold time. Requests that arrive during
// a hold are queued in a saturating counter, and requests beyond its capacity
// are dropped and recorded in a sticky overflow flag.
module edge_to_level_gen #(
  parameter int unsigned MIN_HOLD   = 4,
  parameter int unsigned PEND_DEPTH = 3,
  parameter logic        INIT_LEVEL = 1'b0,
  localparam int unsigned PW        = $clog2(PEND_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          edg_in,
  input  logic          clr_ovf,
  output logic          level,
  output logic          tgl,
  output logic          busy,
  output logic [PW-1:0] pend_cnt,
  output logic          overflow
);

  // Hold counter counts MIN_HOLD-1 down to 0; keep at least one bit for MIN_HOLD=1.
  localparam int unsigned HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;

  localparam logic [HW-1:0] HOLD_RELOAD = HW'(MIN_HOLD - 1);
  localparam logic [PW-1:0] PEND_MAX    = PW'(PEND_DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            level_q, level_d;
  logic            tgl_q, tgl_d;
  logic            busy_q, busy_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic            ovf_q, ovf_d;

  // State, level, hold timer, queue and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      level_q <= INIT_LEVEL;
      tgl_q   <= 1'b0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      tgl_q   <= tgl_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic: toggle on request, enforce hold, queue or drop requests.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    tgl_d   = 1'b0;
    hold_d  = hold_q;
    pend_d  = pend_q;
    // clr_ovf is applied first so that a drop in the same cycle overrides it.
    ovf_d   = clr_ovf ? 1'b0 : ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (edg_in) begin
          level_d = ~level_q;
          tgl_d   = 1'b1;
          hold_d  = HOLD_RELOAD;
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (hold_q != '0) begin
          hold_d = hold_q - HW'(1);
          if (edg_in) begin
            if (pend_q < PEND_MAX) begin
              pend_d = pend_q + PW'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
        end else if ((pend_q != '0) || edg_in) begin
          // Expiry with work to do: a fresh request replaces the consumed one.
          level_d = ~level_q;
          tgl_d   = 1'b1;
          hold_d  = HOLD_RELOAD;
          if (!edg_in) begin
            pend_d = pend_q - PW'(1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_HOLD);
  end

  assign level    = level_q;
  assign tgl      = tgl_q;
  assign busy     = busy_q;
  assign pend_cnt = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_edge_to_level_gen.sv
// Bench for edge_to_level_gen: a vector table for the default configuration
// plus hand-written sequences for reset during a hold and a MIN_HOLD=1 build.
module tb_edge_to_level_gen;

  localparam int unsigned PW = 2;

  logic          clk = 1'b0;
  logic          rst_n, edg_in, clr_ovf;
  logic          level, tgl, busy, overflow;
  logic [PW-1:0] pend_cnt;

  logic          f_rst_n, f_edg, f_clr;
  logic          f_level, f_tgl, f_busy, f_ovf;
  logic [0:0]    f_pend;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  edge_to_level_gen #(.MIN_HOLD(4), .PEND_DEPTH(3), .INIT_LEVEL(1'b0)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .edg_in   (edg_in),
    .clr_ovf  (clr_ovf),
    .level    (level),
    .tgl      (tgl),
    .busy     (busy),
    .pend_cnt (pend_cnt),
    .overflow (overflow)
  );

  edge_to_level_gen #(.MIN_HOLD(1), .PEND_DEPTH(1), .INIT_LEVEL(1'b0)) u_fast (
    .clk      (clk),
    .rst_n    (f_rst_n),
    .edg_in   (f_edg),
    .clr_ovf  (f_clr),
    .level    (f_level),
    .tgl      (f_tgl),
    .busy     (f_busy),
    .pend_cnt (f_pend),
    .overflow (f_ovf)
  );

  typedef struct {
    logic       rst_n;
    logic       edg;
    logic       clr;
    logic       lvl;
    logic       tgl;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic c, input logic l,
                     input logic t, input logic b, input logic [1:0] p, input logic o);
    vec_t v;
    v.rst_n = r; v.edg = e; v.clr = c; v.lvl = l;
    v.tgl = t; v.busy = b; v.pend = p; v.ovf = o;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int n, input logic r, input logic e, input logic c, input logic l,
                       input logic t, input logic b, input logic [1:0] p, input logic o);
    for (int k = 0; k < n; k++) add(r, e, c, l, t, b, p, o);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive inputs away from the active edge, then sample just after it.
  task automatic step(input logic r, input logic e, input logic c);
    @(negedge clk);
    rst_n = r; edg_in = e; clr_ovf = c;
    @(posedge clk);
    #1;
  endtask

  task automatic fstep(input logic r, input logic e);
    @(negedge clk);
    f_rst_n = r; f_edg = e; f_clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic l, input logic t, input logic b,
                         input logic [1:0] p, input logic o);
    chk({tag, ".level"},    32'(level),    32'(l));
    chk({tag, ".tgl"},      32'(tgl),      32'(t));
    chk({tag, ".busy"},     32'(busy),     32'(b));
    chk({tag, ".pend_cnt"}, 32'(pend_cnt), 32'(p));
    chk({tag, ".overflow"}, 32'(overflow), 32'(o));
  endtask

  initial begin
    rst_n = 1'b0; edg_in = 1'b0; clr_ovf = 1'b0;
    f_rst_n = 1'b0; f_edg = 1'b0; f_clr = 1'b0;

    // rst, edg, clr | level, tgl, busy, pend, ovf
    // Reset with requests asserted: nothing toggles.
    add_n(3, 0, 1, 0, 0, 0, 0, 0, 0);
    add_n(2, 1, 0, 0, 0, 0, 0, 0, 0);
    // Single request: busy for MIN_HOLD cycles, then idle.
    add  (1, 1, 0, 1, 1, 1, 0, 0);
    add_n(3, 1, 0, 0, 1, 0, 1, 0, 0);
    add_n(2, 1, 0, 0, 1, 0, 0, 0, 0);
    // Three back-to-back requests: toggles MIN_HOLD apart.
    add  (1, 1, 0, 0, 1, 1, 0, 0);
    add  (1, 1, 0, 0, 0, 1, 1, 0);
    add  (1, 1, 0, 0, 0, 1, 2, 0);
    add  (1, 0, 0, 0, 0, 1, 2, 0);
    add  (1, 0, 0, 1, 1, 1, 1, 0);
    add_n(3, 1, 0, 0, 1, 0, 1, 1, 0);
    add  (1, 0, 0, 0, 1, 1, 0, 0);
    add_n(3, 1, 0, 0, 0, 0, 1, 0, 0);
    add  (1, 0, 0, 0, 0, 0, 0, 0);
    // Continuous requests for six cycles: saturate, expiry replace, drop.
    add  (1, 1, 0, 1, 1, 1, 0, 0);
    add  (1, 1, 0, 1, 0, 1, 1, 0);
    add  (1, 1, 0, 1, 0, 1, 2, 0);
    add  (1, 1, 0, 1, 0, 1, 3, 0);
    add  (1, 1, 0, 0, 1, 1, 3, 0);
    add  (1, 1, 0, 0, 0, 1, 3, 1);
    add_n(2, 1, 0, 0, 0, 0, 1, 3, 1);
    add  (1, 0, 0, 1, 1, 1, 2, 1);
    add_n(3, 1, 0, 0, 1, 0, 1, 2, 1);
    add  (1, 0, 0, 0, 1, 1, 1, 1);
    add_n(3, 1, 0, 0, 0, 0, 1, 1, 1);
    add  (1, 0, 0, 1, 1, 1, 0, 1);
    add_n(3, 1, 0, 0, 1, 0, 1, 0, 1);
    add_n(2, 1, 0, 0, 1, 0, 0, 0, 1);
    // Overflow set and clear in the same cycle: set wins; clear alone works.
    add  (1, 1, 0, 0, 1, 1, 0, 1);
    add  (1, 1, 0, 0, 0, 1, 1, 1);
    add  (1, 1, 0, 0, 0, 1, 2, 1);
    add  (1, 1, 0, 0, 0, 1, 3, 1);
    add  (1, 1, 0, 1, 1, 1, 3, 1);
    add  (1, 1, 1, 1, 0, 1, 3, 1);
    add  (1, 0, 1, 1, 0, 1, 3, 0);
    add  (1, 0, 0, 1, 0, 1, 3, 0);
    add  (1, 0, 0, 0, 1, 1, 2, 0);
    // Reset discards the two queued toggles.
    add  (0, 0, 0, 0, 0, 0, 0, 0);
    add_n(5, 1, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].edg, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].tgl, vecs[i].busy,
              vecs[i].pend, vecs[i].ovf);
    end

    // Reset mid-hold with level=1 and two requests queued.
    step(1, 1, 0); chk_all("rh.p0", 1, 1, 1, 0, 0);
    step(1, 1, 0); chk_all("rh.p1", 1, 0, 1, 1, 0);
    step(1, 1, 0); chk_all("rh.p2", 1, 0, 1, 2, 0);
    step(0, 0, 0); chk_all("rh.rst", 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0); chk_all($sformatf("rh.quiet%0d", i), 0, 0, 0, 0, 0);
    end
    step(1, 1, 0); chk_all("rh.new", 1, 1, 1, 0, 0);
    step(1, 0, 0); chk_all("rh.hold", 1, 0, 1, 0, 0);

    // MIN_HOLD=1: a toggle every cycle, queue never grows.
    fstep(0, 1);
    chk("fast.rst.level", 32'(f_level), 32'(0));
    chk("fast.rst.busy",  32'(f_busy),  32'(0));
    for (int i = 0; i < 4; i++) begin
      fstep(1, 1);
      chk($sformatf("fast%0d.level", i), 32'(f_level), 32'((i % 2 == 0) ? 1 : 0));
      chk($sformatf("fast%0d.tgl", i),   32'(f_tgl),   32'(1));
      chk($sformatf("fast%0d.busy", i),  32'(f_busy),  32'(1));
      chk($sformatf("fast%0d.pend", i),  32'(f_pend),  32'(0));
      chk($sformatf("fast%0d.ovf", i),   32'(f_ovf),   32'(0));
    end
    fstep(1, 0);
    chk("fast.idle.level", 32'(f_level), 32'(0));
    chk("fast.idle.tgl",   32'(f_tgl),   32'(0));
    chk("fast.idle.busy",  32'(f_busy),  32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
